// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master round-robin bus arbiter:
// state encoding and default bus widths.
package bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  // 2'b11 is deliberately left unnamed; the next-state logic folds it back to idle.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_M0   = 2'b01,
    ARB_M1   = 2'b10
  } arb_state_t;

  localparam logic LAST_M0 = 1'b0;
  localparam logic LAST_M1 = 1'b1;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter: grants the shared bus to one master at a time
// and muxes the owner's write strobe, address and data onto the slave bus.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_wr,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic [DATA_W-1:0] m0_din,
  output logic [DATA_W-1:0] m1_din,
  output logic              s_sel,
  output logic              s_wr,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_din,
  input  logic [DATA_W-1:0] s_dout
);

  arb_state_t state_reg, state_next;
  logic       last_reg, last_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ARB_IDLE;
      last_reg  <= LAST_M1;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  // An owner keeps the bus as long as it holds req; a drop hands off directly.
  always_comb begin
    state_next = ARB_IDLE;
    case (state_reg)
      ARB_IDLE: begin
        if (m0_req && m1_req)
          state_next = (last_reg == LAST_M1) ? ARB_M0 : ARB_M1;
        else if (m0_req)
          state_next = ARB_M0;
        else if (m1_req)
          state_next = ARB_M1;
        else
          state_next = ARB_IDLE;
      end
      ARB_M0: begin
        if (m0_req)
          state_next = ARB_M0;
        else if (m1_req)
          state_next = ARB_M1;
        else
          state_next = ARB_IDLE;
      end
      ARB_M1: begin
        if (m1_req)
          state_next = ARB_M1;
        else if (m0_req)
          state_next = ARB_M0;
        else
          state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    last_next = last_reg;
    if (state_next == ARB_M0)
      last_next = LAST_M0;
    else if (state_next == ARB_M1)
      last_next = LAST_M1;
  end

  always_comb begin
    m0_grant  = 1'b0;
    m1_grant  = 1'b0;
    s_sel     = 1'b0;
    s_wr      = 1'b0;
    s_address = '0;
    s_din     = '0;
    case (state_reg)
      ARB_M0: begin
        m0_grant  = 1'b1;
        s_sel     = 1'b1;
        s_wr      = m0_wr;
        s_address = m0_address;
        s_din     = m0_dout;
      end
      ARB_M1: begin
        m1_grant  = 1'b1;
        s_sel     = 1'b1;
        s_wr      = m1_wr;
        s_address = m1_address;
        s_din     = m1_dout;
      end
      default: ;
    endcase
  end

  assign m0_din = s_dout;
  assign m1_din = s_dout;

endmodule
